mem_lsu_stage: RTL and testbench
================================

Name: mem_lsu_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register; consumes its control and data outputs.
- Runs load/store transactions on a req/ready data bus, aligns store data and byte strobes, extracts and extends load data, and stalls the pipeline while a transaction is outstanding.
- Registers the results into the MEM/WB outputs consumed by writeback.

Parameters:
- RAM_WD_SEL, 3'd2, value of EX_MEM_rf_wd_sel that marks a load (writeback data comes from memory).

Ports:
- cpu_clk  in  1  stage clock
- cpu_rst_n  in  1  asynchronous, active-low reset
- EX_MEM_rf_we  in  1  register-file write enable
- EX_MEM_rf_wd_sel  in  3  writeback source select
- EX_MEM_ram_we  in  1  store request
- EX_MEM_ram_op  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- EX_MEM_sext2_op  in  2  bit0=1 zero-extend, 0 sign-extend; bit1 reserved, ignored
- EX_MEM_pc  in  32  instruction PC
- EX_MEM_alu_c  in  32  effective address / ALU result
- EX_MEM_rd1  in  32  store data
- EX_MEM_wR  in  5  destination register
- mem_stall  out  1  freeze EX/MEM and all upstream stages
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  1 = write
- dbus_addr  out  32  word-aligned address ({alu_c[31:2],2'b00})
- dbus_wdata  out  32  lane-replicated store data
- dbus_wstrb  out  4  byte strobes (all 0 on reads)
- dbus_ready  in  1  slave completes in the cycle where req&&ready
- dbus_rdata  in  32  read data, valid when req&&ready
- MEM_WB_rf_we  out  1  registered write enable
- MEM_WB_rf_wd_sel  out  3  registered writeback select
- MEM_WB_wR  out  5  registered destination register
- MEM_WB_pc  out  32  registered PC
- MEM_WB_alu_c  out  32  registered ALU result
- MEM_WB_ram_rd  out  32  aligned and extended load data
- mem_excp  out  1  misaligned-access pulse (feature only; otherwise tied 0)
- mem_badv  out  32  faulting address (feature only; otherwise tied 0)

Behaviour:
- Access is present when EX_MEM_ram_we=1, or when EX_MEM_rf_we=1 and EX_MEM_rf_wd_sel=RAM_WD_SEL.
- FSM states:
  - IDLE: no access → no stall; MEM_WB captures inputs each edge; MEM_WB_ram_rd is 0. Access present → mem_stall=1; at the edge, latch address, size, extension, strobes and wdata; set dbus_req=1; go to BUSY.
  - BUSY: mem_stall=1; dbus_* held stable. dbus_ready=1 → latch aligned read data, drop dbus_req at the edge, go to RESP. dbus_ready=0 → remain in BUSY with no limit.
  - RESP: mem_stall=0; at the edge MEM_WB captures the instruction, with ram_rd taken from the latched value; go to IDLE. EX/MEM advances on the same edge, so no re-issue.
- While mem_stall=1, MEM_WB_rf_we is cleared at every edge (bubble) and the other MEM_WB fields hold.
- Minimum access latency: 3 cycles, with ready in the first BUSY cycle.
- Store lanes:
  - byte: wstrb=1<<a[1:0], wdata={4{rd1[7:0]}}
  - half: wstrb=a[1]?1100:0011, wdata={2{rd1[15:0]}}
  - word: wstrb=1111, wdata=rd1
- Load extract: byte lane a[1:0], half lane a[1], word unchanged. Extension uses sext2_op[0]; word ignores it.
- Without the feature, misaligned half/word accesses ignore a[0] (half) or a[1:0] (word).
- Reset, asynchronous and valid mid-transaction:
  - state → IDLE, dbus_req → 0
  - all MEM_WB outputs, mem_excp, mem_badv and latches → 0
  - an outstanding bus transaction is abandoned; the slave must tolerate req dropping.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined: a half access with a[0]=1, or a word access with a[1:0]≠0, issues no bus request and never stalls. At the edge: MEM_WB_rf_we<=0, mem_excp<=1 for one cycle, mem_badv<=EX_MEM_alu_c, and the other MEM_WB fields capture normally.
- Macro undefined: mem_excp and mem_badv are constant 0, and the force-align rule applies.

Decomposition:
- Shared package mem_pkg holds:
  - ram_op size codes
  - the RAM writeback-select code
  - the extension bit position
  - FSM state enumeration (IDLE, BUSY, RESP)
- Sub-module mem_load_align: combinational lane select plus sign/zero extension; (rdata, addr[1:0], size, zext) → 32-bit result. Reused by any future cache path.

Test Plan:
- ALU op (rf_we=1, wd_sel=0, alu_c=0x1234): no stall, no dbus_req; next edge MEM_WB_alu_c=0x1234, MEM_WB_rf_we=1.
- Signed byte load, alu_c=0x103, rdata=0x80FF_0000, ready at first BUSY cycle: stall for 2 cycles, dbus_addr=0x100; MEM_WB_ram_rd=0xFFFF_FF80 after the RESP edge.
- Half store, alu_c=0x202, rd1=0xABCD_1234, ready delayed 4 cycles: wstrb=1100, wdata=0x1234_1234, held stable across the wait; MEM_WB_rf_we=0 during the stall.
- Zero-extended half load, alu_c=0x002, rdata=0x8001_0000: MEM_WB_ram_rd=0x0000_8001.
- Reset asserted in BUSY: dbus_req=0 and state IDLE immediately; after release, an idle pipeline issues no request.
- MEM_MISALIGN_TRAP_EN, word load at 0x101: no dbus_req, no stall; mem_excp pulses for 1 cycle; mem_badv=0x101; MEM_WB_rf_we=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access-size codes, the
// writeback-select code that marks a load, FSM states and the latched bus
// request, plus the store-lane helpers.
package mem_pkg;

  localparam logic [1:0] OP_BYTE = 2'b00;
  localparam logic [1:0] OP_HALF = 2'b01;
  localparam logic [1:0] OP_WORD = 2'b10;

  localparam logic [2:0] RAM_WD_SEL_C = 3'd2;

  // Bit of EX_MEM_sext2_op selecting zero (1) or sign (0) extension.
  localparam int ZEXT_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Everything the bus and the load aligner need, captured at issue.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        zext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  // Byte strobes for a store; 2'b11 behaves as a word access.
  function automatic logic [3:0] store_strb(input logic [1:0] op, input logic [1:0] a);
    case (op)
      OP_BYTE: store_strb = 4'b0001 << a;
      OP_HALF: store_strb = a[1] ? 4'b1100 : 4'b0011;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane it could land in.
  function automatic logic [31:0] store_data(input logic [1:0] op, input logic [31:0] d);
    case (op)
      OP_BYTE: store_data = {4{d[7:0]}};
      OP_HALF: store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data lane select and sign/zero extension. Purely combinational so a
// cache return path can reuse it unchanged.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        zext_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  // Pick the addressed lane, then extend to 32 bits; word passes through.
  always_comb begin
    case (addr_i)
      2'd0:    b = rdata_i[7:0];
      2'd1:    b = rdata_i[15:8];
      2'd2:    b = rdata_i[23:16];
      default: b = rdata_i[31:24];
    endcase
    h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      OP_BYTE: data_o = zext_i ? {24'b0, b} : {{24{b[7]}}, b};
      OP_HALF: data_o = zext_i ? {16'b0, h} : {{16{h[15]}}, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// Memory-access stage: issues one load/store on the req/ready data bus,
// stalls the pipeline while it is outstanding, and registers MEM/WB.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// raise mem_excp/mem_badv instead of being force-aligned onto the bus.
module mem_lsu_stage
  import mem_pkg::*;
#(
  parameter logic [2:0] RAM_WD_SEL = RAM_WD_SEL_C
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        EX_MEM_rf_we,
  input  logic [2:0]  EX_MEM_rf_wd_sel,
  input  logic        EX_MEM_ram_we,
  input  logic [1:0]  EX_MEM_ram_op,
  input  logic [1:0]  EX_MEM_sext2_op,
  input  logic [31:0] EX_MEM_pc,
  input  logic [31:0] EX_MEM_alu_c,
  input  logic [31:0] EX_MEM_rd1,
  input  logic [4:0]  EX_MEM_wR,
  output logic        mem_stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_ready,
  input  logic [31:0] dbus_rdata,
  output logic        MEM_WB_rf_we,
  output logic [2:0]  MEM_WB_rf_wd_sel,
  output logic [4:0]  MEM_WB_wR,
  output logic [31:0] MEM_WB_pc,
  output logic [31:0] MEM_WB_alu_c,
  output logic [31:0] MEM_WB_ram_rd,
  output logic        mem_excp,
  output logic [31:0] mem_badv
);

  lsu_state_e  state_q, state_d;
  bus_req_t    breq_q, breq_d;
  logic        req_q, req_d;
  logic [31:0] rd_q, rd_d;
  logic        access, misal, trap, stall;
  logic [31:0] ld_data;
  logic        unused_sext;

  // Reserved extension bit is accepted but has no effect.
  assign unused_sext = EX_MEM_sext2_op[1];

  assign access = EX_MEM_ram_we |
                  (EX_MEM_rf_we & (EX_MEM_rf_wd_sel == RAM_WD_SEL));

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = (EX_MEM_ram_op == OP_HALF) ? EX_MEM_alu_c[0] :
                 ((EX_MEM_ram_op != OP_BYTE) && (EX_MEM_alu_c[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  mem_load_align u_align (
    .rdata_i (dbus_rdata),
    .addr_i  (breq_q.addr[1:0]),
    .size_i  (breq_q.size),
    .zext_i  (breq_q.zext),
    .data_o  (ld_data)
  );

  // Transaction FSM: issue from IDLE, wait for ready in BUSY, release in RESP.
  always_comb begin
    state_d = state_q;
    breq_d  = breq_q;
    req_d   = req_q;
    rd_d    = rd_q;
    stall   = 1'b0;
    trap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !misal) begin
          stall        = 1'b1;
          state_d      = BUSY;
          req_d        = 1'b1;
          breq_d.we    = EX_MEM_ram_we;
          breq_d.size  = EX_MEM_ram_op;
          breq_d.zext  = EX_MEM_sext2_op[ZEXT_BIT];
          breq_d.addr  = EX_MEM_alu_c;
          breq_d.wdata = store_data(EX_MEM_ram_op, EX_MEM_rd1);
          breq_d.wstrb = EX_MEM_ram_we ? store_strb(EX_MEM_ram_op, EX_MEM_alu_c[1:0]) : 4'b0000;
        end else if (access) begin
          trap = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dbus_ready) begin
          req_d   = 1'b0;
          rd_d    = breq_q.we ? 32'b0 : ld_data;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall  = stall;
  assign dbus_req   = req_q;
  assign dbus_we    = breq_q.we;
  assign dbus_addr  = {breq_q.addr[31:2], 2'b00};
  assign dbus_wdata = breq_q.wdata;
  assign dbus_wstrb = breq_q.wstrb;

  // FSM state, bus request and load-data latches; reset abandons any access.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= IDLE;
      breq_q  <= '0;
      req_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      breq_q  <= breq_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
    end
  end

  // MEM/WB register: bubble while stalled, otherwise capture the instruction.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      MEM_WB_rf_we     <= 1'b0;
      MEM_WB_rf_wd_sel <= '0;
      MEM_WB_wR        <= '0;
      MEM_WB_pc        <= '0;
      MEM_WB_alu_c     <= '0;
      MEM_WB_ram_rd    <= '0;
    end else if (stall) begin
      MEM_WB_rf_we     <= 1'b0;
    end else begin
      MEM_WB_rf_we     <= EX_MEM_rf_we & ~trap;
      MEM_WB_rf_wd_sel <= EX_MEM_rf_wd_sel;
      MEM_WB_wR        <= EX_MEM_wR;
      MEM_WB_pc        <= EX_MEM_pc;
      MEM_WB_alu_c     <= EX_MEM_alu_c;
      MEM_WB_ram_rd    <= (state_q == RESP) ? rd_q : 32'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic        excp_q;
  logic [31:0] badv_q;

  // One-cycle exception pulse; the faulting address holds until the next fault.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      excp_q <= 1'b0;
      badv_q <= '0;
    end else begin
      excp_q <= trap;
      if (trap) badv_q <= EX_MEM_alu_c;
    end
  end

  assign mem_excp = excp_q;
  assign mem_badv = badv_q;
`else
  assign mem_excp = 1'b0;
  assign mem_badv = 32'b0;
`endif

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Scoreboard bench for mem_lsu_stage: stimulus pushes expected MEM/WB and
// bus transactions; monitors pop and compare when the DUT presents them.
module tb_mem_lsu_stage;
  import mem_pkg::*;

  logic        cpu_clk, cpu_rst_n;
  logic        EX_MEM_rf_we, EX_MEM_ram_we;
  logic [2:0]  EX_MEM_rf_wd_sel;
  logic [1:0]  EX_MEM_ram_op, EX_MEM_sext2_op;
  logic [31:0] EX_MEM_pc, EX_MEM_alu_c, EX_MEM_rd1;
  logic [4:0]  EX_MEM_wR;
  logic        mem_stall, dbus_req, dbus_we, dbus_ready;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_wstrb;
  logic        MEM_WB_rf_we, mem_excp;
  logic [2:0]  MEM_WB_rf_wd_sel;
  logic [4:0]  MEM_WB_wR;
  logic [31:0] MEM_WB_pc, MEM_WB_alu_c, MEM_WB_ram_rd, mem_badv;

  mem_lsu_stage dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .EX_MEM_rf_we(EX_MEM_rf_we), .EX_MEM_rf_wd_sel(EX_MEM_rf_wd_sel),
    .EX_MEM_ram_we(EX_MEM_ram_we), .EX_MEM_ram_op(EX_MEM_ram_op),
    .EX_MEM_sext2_op(EX_MEM_sext2_op), .EX_MEM_pc(EX_MEM_pc),
    .EX_MEM_alu_c(EX_MEM_alu_c), .EX_MEM_rd1(EX_MEM_rd1), .EX_MEM_wR(EX_MEM_wR),
    .mem_stall(mem_stall), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_ready(dbus_ready), .dbus_rdata(dbus_rdata),
    .MEM_WB_rf_we(MEM_WB_rf_we), .MEM_WB_rf_wd_sel(MEM_WB_rf_wd_sel),
    .MEM_WB_wR(MEM_WB_wR), .MEM_WB_pc(MEM_WB_pc), .MEM_WB_alu_c(MEM_WB_alu_c),
    .MEM_WB_ram_rd(MEM_WB_ram_rd), .mem_excp(mem_excp), .mem_badv(mem_badv)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic rf_we; logic [2:0] wd_sel; logic ram_we; logic [1:0] op; logic [1:0] sext;
    logic [31:0] pc, alu, rd1; logic [4:0] wr; int delay; logic [31:0] rdata;
    int exp_stall; logic [31:0] exp_rd; logic exp_bus;
    logic [31:0] exp_addr, exp_wdata; logic [3:0] exp_strb; logic exp_trap;
  } vec_t;

  typedef struct {
    logic rf_we; logic [2:0] wd_sel; logic [4:0] wr; logic [31:0] pc, alu, ram_rd;
  } wb_t;

  typedef struct {
    logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] strb;
  } bus_t;

  wb_t  sb_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t V(input logic rf_we, input logic [2:0] wd_sel, input logic ram_we,
      input logic [1:0] op, input logic [1:0] sext, input logic [31:0] pc, input logic [31:0] alu,
      input logic [31:0] rd1, input logic [4:0] wr, input int delay, input logic [31:0] rdata,
      input int exp_stall, input logic [31:0] exp_rd, input logic exp_bus,
      input logic [31:0] exp_addr, input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
      input logic exp_trap);
    vec_t v;
    v.rf_we = rf_we; v.wd_sel = wd_sel; v.ram_we = ram_we; v.op = op; v.sext = sext;
    v.pc = pc; v.alu = alu; v.rd1 = rd1; v.wr = wr; v.delay = delay; v.rdata = rdata;
    v.exp_stall = exp_stall; v.exp_rd = exp_rd; v.exp_bus = exp_bus;
    v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_strb = exp_strb; v.exp_trap = exp_trap;
    return v;
  endfunction

  task automatic drive_nop();
    EX_MEM_rf_we = 0; EX_MEM_rf_wd_sel = 0; EX_MEM_ram_we = 0; EX_MEM_ram_op = 0;
    EX_MEM_sext2_op = 0; EX_MEM_pc = 0; EX_MEM_alu_c = 0; EX_MEM_rd1 = 0; EX_MEM_wR = 0;
  endtask

  // Issue one instruction at a negedge, act as bus slave, return at the negedge after acceptance.
  task automatic run(input vec_t v);
    int   stalls, busy, guard;
    wb_t  e;
    bus_t b;
    e.rf_we = v.rf_we & ~v.exp_trap; e.wd_sel = v.wd_sel; e.wr = v.wr;
    e.pc = v.pc; e.alu = v.alu; e.ram_rd = v.exp_rd;
    sb_q.push_back(e);
    if (v.exp_bus) begin
      b.addr = v.exp_addr; b.we = v.ram_we; b.wdata = v.exp_wdata; b.strb = v.exp_strb;
      bus_q.push_back(b);
    end
    EX_MEM_rf_we = v.rf_we; EX_MEM_rf_wd_sel = v.wd_sel; EX_MEM_ram_we = v.ram_we;
    EX_MEM_ram_op = v.op; EX_MEM_sext2_op = v.sext; EX_MEM_pc = v.pc;
    EX_MEM_alu_c = v.alu; EX_MEM_rd1 = v.rd1; EX_MEM_wR = v.wr;
    dbus_rdata = v.rdata; dbus_ready = 0;
    stalls = 0; busy = 0; guard = 0;
    forever begin
      if (dbus_req) begin dbus_ready = (busy >= v.delay); busy++; end
      else dbus_ready = 0;
      #1;
      if (!mem_stall) break;
      stalls++; guard++;
      if (guard > 40) begin chk("stall_timeout", 1, 0); break; end
      @(negedge cpu_clk);
    end
    chk("stall_cycles", stalls, v.exp_stall);
    @(negedge cpu_clk);
    dbus_ready = 0;
    chk("mem_excp", mem_excp, v.exp_trap);
    if (v.exp_trap) chk("mem_badv", mem_badv, v.alu);
  endtask

  // MEM/WB monitor: compares after every non-stalled edge; checks bubbles during stalls.
  initial begin
    logic s, prev_s, ok;
    wb_t  e;
    prev_s = 0;
    forever begin
      @(negedge cpu_clk); #2;
      s = mem_stall; ok = cpu_rst_n;
      if (ok && s && prev_s) chk("bubble_rf_we", MEM_WB_rf_we, 0);
      prev_s = ok && s;
      @(posedge cpu_clk); #1;
      if (ok && cpu_rst_n && !s && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("wb_rf_we", MEM_WB_rf_we, e.rf_we);
        chk("wb_wd_sel", MEM_WB_rf_wd_sel, e.wd_sel);
        chk("wb_wR", MEM_WB_wR, e.wr);
        chk("wb_pc", MEM_WB_pc, e.pc);
        chk("wb_alu_c", MEM_WB_alu_c, e.alu);
        chk("wb_ram_rd", MEM_WB_ram_rd, e.ram_rd);
      end
    end
  end

  // Bus monitor: every requesting cycle must match the pending transaction (stability).
  initial begin
    forever begin
      @(negedge cpu_clk); #2;
      if (cpu_rst_n && dbus_req) begin
        if (bus_q.size() == 0) chk("unexpected_req", dbus_req, 0);
        else begin
          chk("bus_addr", dbus_addr, bus_q[0].addr);
          chk("bus_we", dbus_we, bus_q[0].we);
          chk("bus_wstrb", dbus_wstrb, bus_q[0].strb);
          if (bus_q[0].we) chk("bus_wdata", dbus_wdata, bus_q[0].wdata);
          if (dbus_ready) void'(bus_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_t b;
    cpu_rst_n = 0; dbus_ready = 0; dbus_rdata = 0;
    drive_nop();
    repeat (3) @(negedge cpu_clk);
    chk("rst_stall", mem_stall, 0);
    chk("rst_req", dbus_req, 0);
    chk("rst_wb_rf_we", MEM_WB_rf_we, 0);
    chk("rst_wb_pc", MEM_WB_pc, 0);
    chk("rst_wb_ram_rd", MEM_WB_ram_rd, 0);
    chk("rst_excp", mem_excp, 0);
    chk("rst_badv", mem_badv, 0);
    cpu_rst_n = 1;
    @(negedge cpu_clk);

    // rf_we wd_sel ram_we op sext pc alu rd1 wr delay rdata | stall ram_rd bus addr wdata strb trap
    run(V(1, 3'd0, 0, 2'b00, 2'b00, 32'h1000, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0,
          0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0));
    run(V(1, 3'd2, 0, 2'b00, 2'b00, 32'h1004, 32'h0000_0103, 32'h0, 5'd6, 0, 32'h80FF_0000,
          2, 32'hFFFF_FF80, 1, 32'h0000_0100, 32'h0, 4'h0, 0));
    run(V(0, 3'd0, 1, 2'b01, 2'b00, 32'h1008, 32'h0000_0202, 32'hABCD_1234, 5'd0, 4, 32'h0,
          6, 32'h0, 1, 32'h0000_0200, 32'h1234_1234, 4'b1100, 0));
    run(V(1, 3'd2, 0, 2'b01, 2'b01, 32'h100C, 32'h0000_0002, 32'h0, 5'd7, 0, 32'h8001_0000,
          2, 32'h0000_8001, 1, 32'h0000_0000, 32'h0, 4'h0, 0));
    run(V(1, 3'd2, 0, 2'b01, 2'b00, 32'h1010, 32'h0000_0002, 32'h0, 5'd8, 1, 32'h8001_0000,
          3, 32'hFFFF_8001, 1, 32'h0000_0000, 32'h0, 4'h0, 0));
    run(V(0, 3'd0, 1, 2'b00, 2'b00, 32'h1014, 32'h0000_0001, 32'h0000_00A5, 5'd0, 2, 32'h0,
          4, 32'h0, 1, 32'h0000_0000, 32'hA5A5_A5A5, 4'b0010, 0));
    run(V(0, 3'd0, 1, 2'b11, 2'b00, 32'h1018, 32'h0000_0300, 32'hCAFE_F00D, 5'd0, 0, 32'h0,
          2, 32'h0, 1, 32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 0));
    run(V(1, 3'd2, 0, 2'b00, 2'b11, 32'h101C, 32'h0000_0102, 32'h0, 5'd9, 0, 32'h12AB_3456,
          2, 32'h0000_00AB, 1, 32'h0000_0100, 32'h0, 4'h0, 0));
    run(V(1, 3'd2, 0, 2'b10, 2'b00, 32'h1020, 32'h0000_0010, 32'h0, 5'd10, 0, 32'h8000_0001,
          2, 32'h8000_0001, 1, 32'h0000_0010, 32'h0, 4'h0, 0));
    run(V(1, 3'd1, 0, 2'b00, 2'b00, 32'h1024, 32'h0000_5678, 32'h0, 5'd11, 0, 32'h0,
          0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0));

    // Reset while a load is waiting for ready.
    EX_MEM_rf_we = 1; EX_MEM_rf_wd_sel = 3'd2; EX_MEM_ram_we = 0; EX_MEM_ram_op = 2'b10;
    EX_MEM_sext2_op = 0; EX_MEM_pc = 32'h2000; EX_MEM_alu_c = 32'h104; EX_MEM_wR = 5'd12;
    dbus_ready = 0;
    b.addr = 32'h104; b.we = 0; b.wdata = 0; b.strb = 4'h0;
    bus_q.push_back(b);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    #1 chk("pre_rst_req", dbus_req, 1);
    cpu_rst_n = 0;
    drive_nop();
    #1;
    bus_q.delete();
    chk("midrst_req", dbus_req, 0);
    chk("midrst_stall", mem_stall, 0);
    chk("midrst_wb_pc", MEM_WB_pc, 0);
    chk("midrst_wb_alu_c", MEM_WB_alu_c, 0);
    repeat (2) @(negedge cpu_clk);
    cpu_rst_n = 1;
    repeat (3) begin
      @(negedge cpu_clk); #1;
      chk("postrst_req", dbus_req, 0);
      chk("postrst_stall", mem_stall, 0);
    end
    @(negedge cpu_clk);

    run(V(1, 3'd0, 0, 2'b00, 2'b00, 32'h3000, 32'h0000_0042, 32'h0, 5'd13, 0, 32'h0,
          0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0));
`ifdef MEM_MISALIGN_TRAP_EN
    run(V(1, 3'd2, 0, 2'b10, 2'b00, 32'h3004, 32'h0000_0101, 32'h0, 5'd14, 0, 32'hDEAD_BEEF,
          0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 1));
    run(V(0, 3'd0, 0, 2'b00, 2'b00, 32'h3008, 32'h0, 32'h0, 5'd0, 0, 32'h0,
          0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0));
`else
    run(V(1, 3'd2, 0, 2'b01, 2'b01, 32'h3004, 32'h0000_0003, 32'h0, 5'd14, 0, 32'h8001_0000,
          2, 32'h0000_8001, 1, 32'h0000_0000, 32'h0, 4'h0, 0));
    run(V(1, 3'd2, 0, 2'b10, 2'b00, 32'h3008, 32'h0000_0101, 32'h0, 5'd15, 0, 32'hDEAD_BEEF,
          2, 32'hDEAD_BEEF, 1, 32'h0000_0100, 32'h0, 4'h0, 0));
`endif
    run(V(0, 3'd0, 0, 2'b00, 2'b00, 32'h300C, 32'h0, 32'h0, 5'd0, 0, 32'h0,
          0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0));

    chk("sb_drained", sb_q.size(), 0);
    chk("bus_drained", bus_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
